gate_sweep_ctrl: RTL and testbench

Sequencing controller for the basic gate library (Not, Nand, And, Or, Xor). It drives the shared two-input stimulus pair `a`/`b` through all four input combinations and waits a programmable settle time at each one. It then samples the five gate outputs, checks them against the expected truth table, and reports a pass/fail summary. It sits between a test harness (or a self-test request) and the gate datapath, replacing free-running delay-based stimulus with a clocked, repeatable sweep.

---
 rtl/gate_sweep_ctrl.sv | 148 ++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : gate_sweep_ctrl
// Description : Clocked sweep controller for the basic gate library. Drives
//               the shared a/b stimulus through all four input combinations,
//               waits SETTLE_CYCLES at each, checks the five gate outputs
//               against the truth table and reports a pass/fail summary.
//               Optional macro GATE_SWEEP_STOP_ON_FAIL_EN: end the sweep at
//               the first vector that shows a mismatch.
// Revision    : 1.0 - initial release
//==============================================================================
module gate_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] obs,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [4:0] fail_vec
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETTLE = 2'd1;
  localparam logic [1:0] c_CHECK  = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [2:0] c_ERR_MAX     = 3'd4;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [2:0] r_err;
  logic [4:0] r_fail;

  logic [1:0] w_idx_nxt;
  logic       w_a;
  logic       w_b;
  logic [4:0] w_exp;
  logic [4:0] w_mm;
  logic       w_last;
  logic       w_stop;
  logic       w_accept;

  // Stimulus comes straight from the vector index: a toggles fastest.
  assign w_a       = r_idx[0];
  assign w_b       = r_idx[1];
  assign w_idx_nxt = r_idx + 2'd1;

  // Truth table for the current stimulus, same bit order as obs.
  assign w_exp  = {w_a ^ w_b, w_a | w_b, w_a & w_b, ~(w_a & w_b), ~w_a};
  assign w_mm   = obs ^ w_exp;
  assign w_last = (r_idx == 2'd3);

  // A start request only counts while the controller is not sweeping.
  assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign w_stop = |w_mm;
`else
  assign w_stop = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE, c_DONE: begin
        if (w_accept) w_state_nxt = c_SETTLE;
      end
      c_SETTLE: begin
        if (r_cnt == 4'd1) w_state_nxt = c_CHECK;
      end
      c_CHECK: begin
        if (w_last || w_stop) w_state_nxt = c_DONE;
        else                  w_state_nxt = c_SETTLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Vector index, settle counter and result accumulation.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx  <= 2'd0;
      r_cnt  <= 4'd0;
      r_err  <= 3'd0;
      r_fail <= 5'd0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (w_accept) begin
            r_idx  <= 2'd0;
            r_cnt  <= c_SETTLE_LOAD;
            r_err  <= 3'd0;
            r_fail <= 5'd0;
          end
        end
        c_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
        end
        c_CHECK: begin
          r_fail <= r_fail | w_mm;
          if ((w_mm != 5'd0) && (r_err != c_ERR_MAX)) begin
            r_err <= r_err + 3'd1;
          end
          // On the last vector (or an early stop) a/b hold the final vector.
          if (!w_last && !w_stop) begin
            r_idx <= w_idx_nxt;
            r_cnt <= c_SETTLE_LOAD;
          end
        end
        default: begin
          r_idx <= 2'd0;
        end
      endcase
    end
  end

  // Output decode from state and result registers.
  always_comb begin
    a         = w_a;
    b         = w_b;
    busy      = (r_state == c_SETTLE) || (r_state == c_CHECK);
    done      = (r_state == c_DONE);
    pass      = (r_state == c_DONE) && (r_err == 3'd0);
    err_count = r_err;
    fail_vec  = r_fail;
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_gate_sweep_ctrl
// Description : Scoreboard bench for gate_sweep_ctrl. Gate outputs are modelled
//               with injectable stuck-at faults; expected sweep results come
//               from a hand-computed table (with variants for the
//               GATE_SWEEP_STOP_ON_FAIL_EN build).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_gate_sweep_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] obs;
  logic       a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [4:0] fail_vec;

  logic [4:0] s0 = 5'd0;  // stuck-at-0 mask
  logic [4:0] s1 = 5'd0;  // stuck-at-1 mask

  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    logic [4:0] s0;
    logic [4:0] s1;
    int         err;
    logic [4:0] fail;
    int         nv;    // vectors visited
    int         lat;   // cycles busy before done
    logic       a;
    logic       b;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
  } ab_t;

  vec_t res_q[$];
  ab_t  ab_q[$];

  gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .obs       (obs),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clock = ~clock;

  // Gate library model with fault injection.
  always_comb begin
    obs = ({a ^ b, a | b, a & b, ~(a & b), ~a} & ~s0) | s1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Hand-computed expectations for each directed fault scenario.
  function automatic vec_t tv(input int n);
    vec_t v;
    v = '{5'd0, 5'd0, 0, 5'd0, 4, 12, 1'b1, 1'b1};
    case (n)
      1: begin  // xor stuck 0: mismatches at idx 1,2
        v.s0 = 5'b10000;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        v.err = 1; v.fail = 5'b10000; v.nv = 2; v.lat = 6; v.a = 1'b1; v.b = 1'b0;
`else
        v.err = 2; v.fail = 5'b10000;
`endif
      end
      2: begin  // nand stuck 1: mismatch only at idx 3
        v.s1 = 5'b00010; v.err = 1; v.fail = 5'b00010;
      end
      3: begin  // not stuck 0: mismatches at idx 0,2
        v.s0 = 5'b00001;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        v.err = 1; v.fail = 5'b00001; v.nv = 1; v.lat = 3; v.a = 1'b0; v.b = 1'b0;
`else
        v.err = 2; v.fail = 5'b00001;
`endif
      end
      4: begin  // every output stuck 0: all four vectors fail
        v.s0 = 5'b11111;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        v.err = 1; v.fail = 5'b00011; v.nv = 1; v.lat = 3; v.a = 1'b0; v.b = 1'b0;
`else
        v.err = 4; v.fail = 5'b11111;
`endif
      end
      5: begin  // and stuck 1: mismatches at idx 0,1,2
        v.s1 = 5'b00100;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        v.err = 1; v.fail = 5'b00100; v.nv = 1; v.lat = 3; v.a = 1'b0; v.b = 1'b0;
`else
        v.err = 3; v.fail = 5'b00100;
`endif
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    res_q.push_back(v);
    for (int k = 0; k < v.nv; k++) begin
      ab_t e;
      e.a = k[0];
      e.b = k[1];
      ab_q.push_back(e);
    end
  endtask

  task automatic wait_level(input logic lvl, input string name);
    int t;
    t = 0;
    while (done !== lvl && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) chk(name, 0, 1);
  endtask

  // Issue one start pulse, check same-edge clearing, then wait for done.
  task automatic run_sweep(input int n, input bit poke_busy);
    vec_t v;
    v = tv(n);
    s0 = v.s0;
    s1 = v.s1;
    push_exp(v);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("clr_err", int'(err_count), 0);
    chk("clr_fail", int'(fail_vec), 0);
    if (poke_busy) begin
      repeat (3) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_level(1'b1, "timeout_done");
  endtask

  // Monitor: pops expected stimulus and results as the DUT presents them.
  logic p_busy = 1'b0, p_done = 1'b0, p_a = 1'b0, p_b = 1'b0;
  int   cyc = 0;
  always @(negedge clock) begin
    if (mon_en) begin
      if (busy && (!p_busy || a != p_a || b != p_b)) begin
        if (ab_q.size() == 0) chk("unexpected_vec", 1, 0);
        else begin
          ab_t e;
          e = ab_q.pop_front();
          chk("vec_a", int'(a), int'(e.a));
          chk("vec_b", int'(b), int'(e.b));
        end
      end
      if (busy && !p_busy) cyc = 1;
      else if (busy) cyc++;
      if (done && !p_done) begin
        if (res_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          vec_t v;
          v = res_q.pop_front();
          chk("err_count", int'(err_count), v.err);
          chk("fail_vec", int'(fail_vec), int'(v.fail));
          chk("pass", int'(pass), (v.err == 0) ? 1 : 0);
          chk("final_a", int'(a), int'(v.a));
          chk("final_b", int'(b), int'(v.b));
          chk("latency", cyc, v.lat);
        end
      end
    end
    p_busy = busy;
    p_done = done;
    p_a    = a;
    p_b    = b;
  end

  initial begin
    int t;
    repeat (3) @(negedge clock);
    chk("rst_a", int'(a), 0);
    chk("rst_b", int'(b), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_fail", int'(fail_vec), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);

    // Directed fault scenarios, each started from DONE after the first.
    for (int n = 0; n <= 5; n++) run_sweep(n, 1'b0);
    // Restart from DONE after a failing sweep with ideal gates.
    run_sweep(0, 1'b0);
    // Start pulse while busy must not disturb sequence or timing.
    run_sweep(1, 1'b1);

    // Reset during SETTLE of idx 2: vectors 0..2 appear, no result.
    begin
      vec_t v;
      v = tv(0);
      s0 = 5'd0;
      s1 = 5'd0;
      for (int k = 0; k < 3; k++) begin
        ab_t e;
        e.a = k[0];
        e.b = k[1];
        ab_q.push_back(e);
      end
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      t = 0;
      while (!(busy && a == 1'b0 && b == 1'b1) && t < 50) begin
        @(negedge clock);
        t++;
      end
      if (t >= 50) chk("timeout_idx2", 0, 1);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_ab", int'({a, b}), 0);
      chk("mid_rst_err", int'(err_count), 0);
      chk("mid_rst_fail", int'(fail_vec), 0);
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_idle", int'(busy), 0);
    end
    run_sweep(0, 1'b0);

    // Start held high: re-sweep one cycle after DONE entry.
    push_exp(tv(0));
    push_exp(tv(0));
    start = 1'b1;
    @(negedge clock);
    wait_level(1'b1, "timeout_hold1");
    @(negedge clock);
    chk("hold_resweep_busy", int'(busy), 1);
    wait_level(1'b1, "timeout_hold2");
    start = 1'b0;

    repeat (5) @(negedge clock);
    chk("res_q_empty", res_q.size(), 0);
    chk("ab_q_empty", ab_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
